// File: rtl/exec_ctrl_unit.sv
// Execute-stage control and compute block for the MIPS-Lite4 core.
// The decoder, B-operand mux, ALU, Zero flag and byte-enable logic feed a single EX output register.
module exec_ctrl_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic [31:0]      Instr_i,
    input  logic [WIDTH-1:0] Rd1_i,
    input  logic [WIDTH-1:0] Rd2_i,
    input  logic [WIDTH-1:0] Imm_ext_i,
    output logic             Extop_o,
    output logic [1:0]       Regdst_o,
    output logic             Alusrc_o,
    output logic             Memwrite_o,
    output logic [1:0]       Memtoreg_o,
    output logic             Regwrite_o,
    output logic [1:0]       nPC_sel_o,
    output logic [2:0]       Aluop_o,
    output logic [WIDTH-1:0] C_o,
    output logic             Zero_o,
    output logic [3:0]       Membe_o,
    output logic             Sign_o
);

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_LUI = 3'b101;

    localparam logic [2:0] BE_WORD   = 3'b000;
    localparam logic [2:0] BE_HALF_S = 3'b001;
    localparam logic [2:0] BE_HALF_U = 3'b010;
    localparam logic [2:0] BE_BYTE_S = 3'b011;
    localparam logic [2:0] BE_BYTE_U = 3'b100;

    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_ADD: alu_f = a + b;
            ALU_SUB: alu_f = a - b;
            ALU_OR:  alu_f = a | b;
            ALU_AND: alu_f = a & b;
            ALU_SLT: alu_f = {{(WIDTH-1){1'b0}}, (sa < sb)};
            ALU_LUI: alu_f = {b[15:0], {(WIDTH-16){1'b0}}};
            default: alu_f = '0;
        endcase
    endfunction

    // Alignment is not checked: word ignores both address bits, half ignores a[0].
    function automatic logic [3:0] be_f(input logic [2:0] sel, input logic [1:0] a);
        case (sel)
            BE_WORD:              be_f = 4'b1111;
            BE_HALF_S, BE_HALF_U: be_f = a[1] ? 4'b1100 : 4'b0011;
            BE_BYTE_S, BE_BYTE_U: be_f = 4'b0001 << a;
            default:              be_f = 4'b0000;
        endcase
    endfunction

    logic [5:0] op;
    logic [5:0] func;
    logic       unused_instr;

    assign op           = Instr_i[31:26];
    assign func         = Instr_i[5:0];
    assign unused_instr = ^Instr_i[25:6];

    logic             extop_d;
    logic [1:0]       regdst_d;
    logic             alusrc_d;
    logic             memwrite_d;
    logic [1:0]       memtoreg_d;
    logic             regwrite_d;
    logic [1:0]       npc_sel_d;
    logic [2:0]       aluop_d;
    logic             mem_d;
    logic [2:0]       be_sel_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] c_d;
    logic             zero_d;
    logic [3:0]       membe_d;
    logic             sign_d;

    always_comb begin
        extop_d    = 1'b0;
        regdst_d   = 2'b00;
        alusrc_d   = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 2'b00;
        regwrite_d = 1'b0;
        npc_sel_d  = 2'b00;
        aluop_d    = ALU_ADD;
        mem_d      = 1'b0;
        be_sel_d   = BE_WORD;
        case (op)
            OP_R: begin
                case (func)
                    F_ADDU: begin regdst_d = 2'b01; regwrite_d = 1'b1; aluop_d = ALU_ADD; end
                    F_SUBU: begin regdst_d = 2'b01; regwrite_d = 1'b1; aluop_d = ALU_SUB; end
                    F_AND:  begin regdst_d = 2'b01; regwrite_d = 1'b1; aluop_d = ALU_AND; end
                    F_OR:   begin regdst_d = 2'b01; regwrite_d = 1'b1; aluop_d = ALU_OR;  end
                    F_SLT:  begin regdst_d = 2'b01; regwrite_d = 1'b1; aluop_d = ALU_SLT; end
                    F_JR:   npc_sel_d = 2'b11;
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alusrc_d = 1'b1; regwrite_d = 1'b1; extop_d = 1'b1; aluop_d = ALU_ADD;
            end
            OP_ORI: begin
                alusrc_d = 1'b1; regwrite_d = 1'b1; aluop_d = ALU_OR;
            end
            OP_LUI: begin
                alusrc_d = 1'b1; regwrite_d = 1'b1; aluop_d = ALU_LUI;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                alusrc_d   = 1'b1;
                extop_d    = 1'b1;
                regwrite_d = 1'b1;
                memtoreg_d = 2'b01;
                mem_d      = 1'b1;
                case (op)
                    OP_LB:   be_sel_d = BE_BYTE_S;
                    OP_LBU:  be_sel_d = BE_BYTE_U;
                    OP_LH:   be_sel_d = BE_HALF_S;
                    OP_LHU:  be_sel_d = BE_HALF_U;
                    default: be_sel_d = BE_WORD;
                endcase
            end
            OP_SW, OP_SH, OP_SB: begin
                alusrc_d   = 1'b1;
                extop_d    = 1'b1;
                memwrite_d = 1'b1;
                mem_d      = 1'b1;
                case (op)
                    OP_SH:   be_sel_d = BE_HALF_U;
                    OP_SB:   be_sel_d = BE_BYTE_U;
                    default: be_sel_d = BE_WORD;
                endcase
            end
            OP_BEQ: begin
                aluop_d = ALU_SUB; npc_sel_d = 2'b01;
            end
            OP_J: npc_sel_d = 2'b10;
            OP_JAL: begin
                npc_sel_d = 2'b10; regdst_d = 2'b10; memtoreg_d = 2'b10; regwrite_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign b_d     = alusrc_d ? Imm_ext_i : Rd2_i;
    assign c_d     = alu_f(aluop_d, Rd1_i, b_d);
    assign zero_d  = (c_d == '0);
    assign membe_d = mem_d ? be_f(be_sel_d, c_d[1:0]) : 4'b0000;
    assign sign_d  = mem_d && ((be_sel_d == BE_HALF_S) || (be_sel_d == BE_BYTE_S));

    assign Extop_o = extop_d;

    logic [1:0]       regdst_q;
    logic             alusrc_q;
    logic             memwrite_q;
    logic [1:0]       memtoreg_q;
    logic             regwrite_q;
    logic [1:0]       npc_sel_q;
    logic [2:0]       aluop_q;
    logic [WIDTH-1:0] c_q;
    logic             zero_q;
    logic [3:0]       membe_q;
    logic             sign_q;

    // EX stage register: the all-zero reset value doubles as a NOP.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            regdst_q   <= 2'b00;
            alusrc_q   <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 2'b00;
            regwrite_q <= 1'b0;
            npc_sel_q  <= 2'b00;
            aluop_q    <= 3'b000;
            c_q        <= '0;
            zero_q     <= 1'b0;
            membe_q    <= 4'b0000;
            sign_q     <= 1'b0;
        end else begin
            regdst_q   <= regdst_d;
            alusrc_q   <= alusrc_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            npc_sel_q  <= npc_sel_d;
            aluop_q    <= aluop_d;
            c_q        <= c_d;
            zero_q     <= zero_d;
            membe_q    <= membe_d;
            sign_q     <= sign_d;
        end
    end

    assign Regdst_o   = regdst_q;
    assign Alusrc_o   = alusrc_q;
    assign Memwrite_o = memwrite_q;
    assign Memtoreg_o = memtoreg_q;
    assign Regwrite_o = regwrite_q;
    assign nPC_sel_o  = npc_sel_q;
    assign Aluop_o    = aluop_q;
    assign C_o        = c_q;
    assign Zero_o     = zero_q;
    assign Membe_o    = membe_q;
    assign Sign_o     = sign_q;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// Directed bench for exec_ctrl_unit: one instruction per clock, outputs checked 1 ns after the edge.
module tb_exec_ctrl_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] Instr;
    logic [31:0] Rd1;
    logic [31:0] Rd2;
    logic [31:0] Imm_ext;
    logic        Extop;
    logic [1:0]  Regdst;
    logic        Alusrc;
    logic        Memwrite;
    logic [1:0]  Memtoreg;
    logic        Regwrite;
    logic [1:0]  nPC_sel;
    logic [2:0]  Aluop;
    logic [31:0] C;
    logic        Zero;
    logic [3:0]  Membe;
    logic        Sign;

    int n_chk  = 0;
    int n_pass = 0;

    exec_ctrl_unit #(.WIDTH(32)) dut (
        .Clk_i(Clk), .Reset_i(Reset), .Instr_i(Instr), .Rd1_i(Rd1), .Rd2_i(Rd2),
        .Imm_ext_i(Imm_ext), .Extop_o(Extop), .Regdst_o(Regdst), .Alusrc_o(Alusrc),
        .Memwrite_o(Memwrite), .Memtoreg_o(Memtoreg), .Regwrite_o(Regwrite),
        .nPC_sel_o(nPC_sel), .Aluop_o(Aluop), .C_o(C), .Zero_o(Zero),
        .Membe_o(Membe), .Sign_o(Sign)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o);
        return {o, 26'd0};
    endfunction

    // {Regdst, Alusrc, Memwrite, Memtoreg, Regwrite, nPC_sel, Aluop}
    function automatic logic [31:0] ctl();
        return {20'd0, Regdst, Alusrc, Memwrite, Memtoreg, Regwrite, nPC_sel, Aluop};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        Instr = ins; Rd1 = a; Rd2 = b; Imm_ext = imm;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Instr = 32'h0; Rd1 = 32'h0; Rd2 = 32'h0; Imm_ext = 32'h0;
        #2;
        chk("rst_ctl", ctl(), 32'h0);
        chk("rst_c", C, 32'h0);
        chk("rst_zero", {31'd0, Zero}, 32'h0);
        chk("rst_membe_sign", {27'd0, Membe, Sign}, 32'h0);

        @(negedge Clk);
        Reset = 1'b0;
        issue(32'h0, 32'h0, 32'h0, 32'h0);
        chk("nop_ctl", ctl(), 32'h0);
        chk("nop_c", C, 32'h0);
        chk("nop_membe_sign", {27'd0, Membe, Sign}, 32'h0);

        issue(rtype(6'b100001), 32'd5, 32'd7, 32'h0);
        chk("addu_c", C, 32'd12);
        chk("addu_zero", {31'd0, Zero}, 32'd0);
        chk("addu_regdst", {30'd0, Regdst}, 32'd1);
        chk("addu_regwrite", {31'd0, Regwrite}, 32'd1);
        chk("addu_membe", {28'd0, Membe}, 32'h0);

        // Asynchronous reset mid-cycle, checked before the next edge.
        Reset = 1'b1;
        #1;
        chk("midrst_c", C, 32'h0);
        chk("midrst_ctl", ctl(), 32'h0);
        #1;
        Reset = 1'b0;

        issue(itype(6'b000100), 32'h1234, 32'h1234, 32'h0);
        chk("beq_eq_c", C, 32'h0);
        chk("beq_eq_zero", {31'd0, Zero}, 32'd1);
        chk("beq_npc", {30'd0, nPC_sel}, 32'd1);
        chk("beq_regwrite", {31'd0, Regwrite}, 32'd0);
        issue(itype(6'b000100), 32'h1234, 32'h1235, 32'h0);
        chk("beq_ne_c", C, 32'hFFFF_FFFF);
        chk("beq_ne_zero", {31'd0, Zero}, 32'd0);

        issue(itype(6'b001111), 32'hDEAD_BEEF, 32'h0, 32'h0000_1234);
        chk("lui_c", C, 32'h1234_0000);
        chk("lui_alusrc", {31'd0, Alusrc}, 32'd1);
        issue(rtype(6'b101010), 32'hFFFF_FFFF, 32'd1, 32'h0);
        chk("slt_neg_c", C, 32'd1);
        issue(rtype(6'b101010), 32'd1, 32'hFFFF_FFFF, 32'h0);
        chk("slt_pos_c", C, 32'd0);
        issue(rtype(6'b100011), 32'd3, 32'd5, 32'h0);
        chk("subu_c", C, 32'hFFFF_FFFE);
        issue(rtype(6'b100100), 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        chk("and_c", C, 32'h0000_F000);
        issue(rtype(6'b100101), 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        chk("or_c", C, 32'h0000_FFF0);
        issue(itype(6'b001101), 32'h00FF_0000, 32'h1111_1111, 32'h0000_00FF);
        chk("ori_c", C, 32'h00FF_00FF);
        issue(itype(6'b001000), 32'hFFFF_FFFF, 32'h0, 32'd2);
        chk("addi_wrap_c", C, 32'd1);

        issue(itype(6'b100000), 32'h100, 32'h0, 32'd3);
        chk("lb_c", C, 32'h103);
        chk("lb_membe", {28'd0, Membe}, 32'b1000);
        chk("lb_sign", {31'd0, Sign}, 32'd1);
        chk("lb_memtoreg", {30'd0, Memtoreg}, 32'd1);
        issue(itype(6'b100101), 32'h100, 32'h0, 32'd2);
        chk("lhu_membe", {28'd0, Membe}, 32'b1100);
        chk("lhu_sign", {31'd0, Sign}, 32'd0);
        issue(itype(6'b100001), 32'h100, 32'h0, 32'd3);
        chk("lh_membe", {28'd0, Membe}, 32'b1100);
        chk("lh_sign", {31'd0, Sign}, 32'd1);

        issue(itype(6'b101001), 32'h100, 32'h0, 32'd0);
        chk("sh_membe", {28'd0, Membe}, 32'b0011);
        chk("sh_memwrite", {31'd0, Memwrite}, 32'd1);
        chk("sh_regwrite_sign", {30'd0, Regwrite, Sign}, 32'd0);
        issue(itype(6'b101000), 32'h100, 32'h0, 32'd1);
        chk("sb_membe", {28'd0, Membe}, 32'b0010);
        issue(itype(6'b101011), 32'h100, 32'h0, 32'd2);
        chk("sw_membe", {28'd0, Membe}, 32'b1111);

        issue(itype(6'b000011), 32'h0, 32'h0, 32'h0);
        chk("jal_regdst", {30'd0, Regdst}, 32'd2);
        chk("jal_memtoreg", {30'd0, Memtoreg}, 32'd2);
        chk("jal_npc", {30'd0, nPC_sel}, 32'd2);
        chk("jal_regwrite", {31'd0, Regwrite}, 32'd1);
        issue(rtype(6'b001000), 32'h40, 32'h0, 32'h0);
        chk("jr_npc", {30'd0, nPC_sel}, 32'd3);

        issue(itype(6'b111111), 32'h0, 32'h0, 32'h0);
        chk("badop_ctl", ctl(), 32'h0);
        chk("badop_c", C, 32'h0);
        chk("badop_membe_sign", {27'd0, Membe, Sign}, 32'h0);

        // Extop follows Instr with no clock edge.
        Instr = itype(6'b001000); #1;
        chk("extop_addi", {31'd0, Extop}, 32'd1);
        Instr = itype(6'b001101); #1;
        chk("extop_ori", {31'd0, Extop}, 32'd0);
        Instr = itype(6'b101011); #1;
        chk("extop_sw", {31'd0, Extop}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_ctrl_unit.md
Name: exec_ctrl_unit

Overview:
- Execute-stage control/compute block for the MIPS-Lite4 single-issue core.
- Decodes op/func into datapath controls, selects the ALU B operand, and computes the ALU result and Zero flag.
- Derives memory byte enables and load sign from the result's low address bits.
- All results except Extop are captured in an output register: a one-cycle EX pipeline stage.

Parameters:
- WIDTH, 32, datapath width (only 32 supported).

Ports:
- Clk in 1: clock, rising edge.
- Reset in 1: asynchronous, active-high; clears all registered outputs.
- Instr in 32: current instruction (op = [31:26], func = [5:0]).
- Rd1 in 32: rs register value (ALU A).
- Rd2 in 32: rt register value.
- Imm_ext in 32: extended immediate from external extender.
- Extop out 1: combinational; 1 = sign-extend, 0 = zero-extend. Feeds the extender in the same cycle.
- Regdst out 2: 00 = rt, 01 = rd, 10 = $31.
- Alusrc out 1: 0 = Rd2, 1 = Imm_ext.
- Memwrite out 1: data-memory write.
- Memtoreg out 2: 00 = ALU, 01 = DM, 10 = PC+4.
- Regwrite out 1: register-file write.
- nPC_sel out 2: 00 = PC+4, 01 = beq, 10 = j/jal, 11 = jr.
- Aluop out 3: ALU function.
- C out 32: ALU result.
- Zero out 1: C == 0.
- Membe out 4: byte enables, bit i = byte i.
- Sign out 1: 1 = sign-extend the loaded sub-word.

Behaviour:
- Reset (async, active-high) forces every registered output to 0. This all-zero state is a NOP: no writes, nPC_sel = PC+4. Reset may assert mid-operation; outputs clear immediately and hold 0 while Reset is high.
- The registered outputs (all except Extop) load the combinational next values on each rising Clk edge. Latency is exactly 1 cycle; there is no stall or enable.
- Decode table (unlisted fields = 0):
  - addu (R, func 100001): Regdst 01, Regwrite, Aluop ADD.
  - subu (R, func 100011): Regdst 01, Regwrite, Aluop SUB.
  - and (R, func 100100): Regdst 01, Regwrite, Aluop AND.
  - or (R, func 100101): Regdst 01, Regwrite, Aluop OR.
  - slt (R, func 101010): Regdst 01, Regwrite, Aluop SLT.
  - jr (R, func 001000): nPC_sel 11.
  - addi 001000 / addiu 001001: Alusrc, Regwrite, Extop 1, ADD.
  - ori 001101: Alusrc, Regwrite, Extop 0, OR.
  - lui 001111: Alusrc, Regwrite, LUI.
  - lw 100011: Alusrc, Extop, Regwrite, Memtoreg 01, ADD, BE_sel word.
  - lb 100000 / lbu 100100: as lw but byte, signed / unsigned.
  - lh 100001 / lhu 100101: as lw but half, signed / unsigned.
  - sw 101011 / sh 101001 / sb 101000: Alusrc, Extop, Memwrite, ADD; BE_sel word / half unsigned / byte unsigned.
  - beq 000100: Aluop SUB, nPC_sel 01.
  - j 000010: nPC_sel 10.
  - jal 000011: nPC_sel 10, Regdst 10, Memtoreg 10, Regwrite.
  - Any other op or R-func: all controls 0 (NOP).
- Aluop encoding: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 SLT, 101 LUI, 110/111 result 0.
  - ALU A = Rd1; B = Alusrc ? Imm_ext : Rd2.
  - ADD/SUB wrap modulo 2^32; no overflow trap.
  - SLT is a signed compare giving 1 or 0.
  - LUI gives B[15:0] followed by 16 zero bits.
- Zero is computed from the same C that is registered.
- BE_sel is internal: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned.
- Byte enables, using a = C[1:0]:
  - word: Membe 1111; a is ignored (no misalignment check).
  - half: a[1]=0 gives 0011, a[1]=1 gives 1100; a[0] ignored.
  - byte: one-hot at bit a.
  - Sign = 1 only for 001 and 011.
  - Non-memory instructions: Membe 0000, Sign 0.
- Extop is purely combinational from Instr and is not reset.

Test Plan:
- Reset high: all registered outputs 0 immediately, with no clock edge; after release and a NOP instruction they remain 0.
- addu with Rd1 = 5, Rd2 = 7, one edge: C = 12, Zero 0, Regdst 01, Regwrite 1, Membe 0000.
- beq with Rd1 = Rd2 = 0x1234: C = 0, Zero 1, nPC_sel 01, Regwrite 0. With 0x1234 vs 0x1235: C = 0xFFFFFFFF, Zero 0.
- lui with Imm_ext = 0x00001234: C = 0x12340000, Alusrc 1. slt with Rd1 = 0xFFFFFFFF, Rd2 = 1: C = 1.
- Loads: lb with Rd1 = 0x100, Imm_ext = 3 gives Membe 1000, Sign 1, Memtoreg 01. lhu at address 0x102 gives Membe 1100, Sign 0.
- Stores and others: sh at address 0x100 gives Membe 0011, Memwrite 1. jal gives Regdst 10, Memtoreg 10, nPC_sel 10. Op 111111 gives all registered outputs 0.
